// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
);
  logic                  cpu_req_in;
  logic                  cpu_wr_in;
  logic [ADDR_WIDTH-1:0] cpu_addr_in;
  logic [DATA_WIDTH-1:0] cpu_data_in;
  logic [DATA_WIDTH-1:0] cpu_data_out;
  logic                  cpu_ack_out;

  logic                  host_req_in;
  logic                  host_wr_in;
  logic [ADDR_WIDTH-1:0] host_addr_in;
  logic [DATA_WIDTH-1:0] host_data_in;
  logic [DATA_WIDTH-1:0] host_data_out;
  logic                  host_ack_out;
  logic                  host_lock_in;

  logic                  mem_en_out;
  logic                  mem_wr_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic [DATA_WIDTH-1:0] mem_data_in;

  logic                  busy_out;

  modport slave (
    input  cpu_req_in, cpu_wr_in, cpu_addr_in, cpu_data_in,
    output cpu_data_out, cpu_ack_out,
    input  host_req_in, host_wr_in, host_addr_in, host_data_in, host_lock_in,
    output host_data_out, host_ack_out,
    output mem_en_out, mem_wr_out, mem_addr_out, mem_data_out,
    input  mem_data_in,
    output busy_out
  );

  modport master (
    output cpu_req_in, cpu_wr_in, cpu_addr_in, cpu_data_in,
    input  cpu_data_out, cpu_ack_out,
    output host_req_in, host_wr_in, host_addr_in, host_data_in, host_lock_in,
    input  host_data_out, host_ack_out,
    input  mem_en_out, mem_wr_out, mem_addr_out, mem_data_out,
    output mem_data_in,
    input  busy_out
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory;
// every access is arbitrate / access / respond, and the host can lock out the CPU.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a request; grant and latch the winner's command
// ACC_CPU  | memory enabled with the latched CPU command
// ACC_HOST | memory enabled with the latched host command
// RSP_CPU  | cpu_ack_out strobe; read data passes through and is captured
// RSP_HOST | host_ack_out strobe; read data passes through and is captured
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 11
) (
  input  logic              clock_in,
  input  logic              reset_in,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC_CPU,
    S_ACC_HOST,
    S_RSP_CPU,
    S_RSP_HOST
  } state_t;

  state_t                state_q, state_d;
  logic                  last_host_q, last_host_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;

  logic                  cpu_ok;
  logic                  grant_cpu, grant_host;
  logic                  mem_en, mem_wr;
  logic                  cpu_ack, host_ack;
  logic [DATA_WIDTH-1:0] cpu_rd, host_rd;

  assign cpu_ok = bus.cpu_req_in & ~bus.host_lock_in;

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= S_IDLE;
      last_host_q  <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_host_q  <= last_host_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_host_d  = last_host_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    grant_cpu    = 1'b0;
    grant_host   = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    cpu_ack      = 1'b0;
    host_ack     = 1'b0;
    cpu_rd       = cpu_rdata_q;
    host_rd      = host_rdata_q;

    case (state_q)
      S_IDLE: begin
        // On contention the port that did not win last time goes first.
        if (cpu_ok && bus.host_req_in) begin
          grant_cpu  = last_host_q;
          grant_host = ~last_host_q;
        end else begin
          grant_cpu  = cpu_ok;
          grant_host = bus.host_req_in;
        end
        if (grant_cpu) begin
          state_d     = S_ACC_CPU;
          last_host_d = 1'b0;
          wr_d        = bus.cpu_wr_in;
          addr_d      = bus.cpu_addr_in;
          wdata_d     = bus.cpu_data_in;
        end else if (grant_host) begin
          state_d     = S_ACC_HOST;
          last_host_d = 1'b1;
          wr_d        = bus.host_wr_in;
          addr_d      = bus.host_addr_in;
          wdata_d     = bus.host_data_in;
        end
      end
      S_ACC_CPU: begin
        mem_en  = 1'b1;
        mem_wr  = wr_q;
        state_d = S_RSP_CPU;
      end
      S_ACC_HOST: begin
        mem_en  = 1'b1;
        mem_wr  = wr_q;
        state_d = S_RSP_HOST;
      end
      S_RSP_CPU: begin
        cpu_ack = 1'b1;
        if (!wr_q) begin
          cpu_rd      = bus.mem_data_in;
          cpu_rdata_d = bus.mem_data_in;
        end
        state_d = S_IDLE;
      end
      S_RSP_HOST: begin
        host_ack = 1'b1;
        if (!wr_q) begin
          host_rd      = bus.mem_data_in;
          host_rdata_d = bus.mem_data_in;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Address/data come straight from the latches, so they hold outside ACC.
  assign bus.mem_en_out    = mem_en;
  assign bus.mem_wr_out    = mem_wr;
  assign bus.mem_addr_out  = addr_q;
  assign bus.mem_data_out  = wdata_q;
  assign bus.cpu_ack_out   = cpu_ack;
  assign bus.host_ack_out  = host_ack;
  assign bus.cpu_data_out  = cpu_rd;
  assign bus.host_data_out = host_rd;
  assign bus.busy_out      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts which
// port is served, when its access and ack land, and what data each port reads.
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 11;

  logic clock_in = 1'b0;
  logic reset_in = 1'b0;
  logic mem_clr  = 1'b1;

  always #5 clock_in = ~clock_in;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  // Memory with one-cycle read latency.
  logic [DW-1:0] mem_env [2048];
  logic [DW-1:0] mem_rd;
  always @(posedge clock_in) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mem_env[i] <= '0;
      mem_rd <= '0;
    end else if (bus.mem_en_out) begin
      if (bus.mem_wr_out) mem_env[bus.mem_addr_out] <= bus.mem_data_out;
      else                mem_rd <= mem_env[bus.mem_addr_out];
    end
  end
  assign bus.mem_data_in = mem_rd;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference: memory contents and per-port held read data.
  logic [DW-1:0] refmem [2048];
  logic [DW-1:0] held   [2];

  // Requesters (0 = CPU, 1 = host).
  bit            pend [2];
  bit            wr   [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] data [2];
  int            rem  [2];
  bit            rand_mode = 0;
  bit            lock      = 0;
  bit            pg_fixed  = 0;
  logic [AW-1:0] pg_addr   = '0;

  // Transaction in service.
  bit            in_flight = 0;
  int            g_cyc     = 0;
  int            t_port    = 0;
  bit            t_wr      = 0;
  logic [AW-1:0] t_addr    = '0;
  logic [DW-1:0] t_data    = '0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;
  bit            last_host = 1;

  int log_port [$];
  int log_cyc  [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 11'h7FF - 11'($urandom_range(0, 3));
    return 11'($urandom_range(0, 15));
  endfunction

  task automatic newtx(input int p);
    pend[p] = 1;
    wr[p]   = 1'($urandom_range(0, 1));
    addr[p] = rand_addr();
    data[p] = 16'($urandom);
  endtask

  task automatic drive();
    bus.host_lock_in = lock;
    bus.cpu_req_in   = pend[0];
    bus.host_req_in  = pend[1];
    if (in_flight && t_port == 0) begin
      bus.cpu_wr_in   = 1'($urandom_range(0, 1));
      bus.cpu_addr_in = pg_fixed ? pg_addr : 11'($urandom);
      bus.cpu_data_in = 16'($urandom);
    end else begin
      bus.cpu_wr_in   = wr[0];
      bus.cpu_addr_in = addr[0];
      bus.cpu_data_in = data[0];
    end
    if (in_flight && t_port == 1) begin
      bus.host_wr_in   = 1'($urandom_range(0, 1));
      bus.host_addr_in = pg_fixed ? pg_addr : 11'($urandom);
      bus.host_data_in = 16'($urandom);
    end else begin
      bus.host_wr_in   = wr[1];
      bus.host_addr_in = addr[1];
      bus.host_data_in = data[1];
    end
  endtask

  // One clock: check the DUT against the model, then advance the model.
  task automatic step();
    int            age;
    bit            idle_now;
    bit            cpu_ok;
    int            gp;
    logic [DW-1:0] exp_c, exp_h;
    @(negedge clock_in);
    cyc++;
    age      = in_flight ? (cyc - g_cyc) : -1;
    idle_now = !in_flight;

    chk("busy",      32'(bus.busy_out),     32'(in_flight));
    chk("mem_en",    32'(bus.mem_en_out),   32'(age == 1));
    chk("mem_wr",    32'(bus.mem_wr_out),   32'(age == 1 && t_wr));
    chk("mem_addr",  32'(bus.mem_addr_out), 32'(last_addr));
    chk("mem_data",  32'(bus.mem_data_out), 32'(last_data));
    chk("cpu_ack",   32'(bus.cpu_ack_out),  32'(age == 2 && t_port == 0));
    chk("host_ack",  32'(bus.host_ack_out), 32'(age == 2 && t_port == 1));
    exp_c = (age == 2 && t_port == 0 && !t_wr) ? refmem[t_addr] : held[0];
    exp_h = (age == 2 && t_port == 1 && !t_wr) ? refmem[t_addr] : held[1];
    chk("cpu_data",  32'(bus.cpu_data_out),  32'(exp_c));
    chk("host_data", 32'(bus.host_data_out), 32'(exp_h));

    if (age == 2) begin
      if (t_wr) refmem[t_addr] = t_data;
      else      held[t_port]   = refmem[t_addr];
      pend[t_port] = 0;
      log_port.push_back(t_port);
      log_cyc.push_back(cyc);
      in_flight = 0;
    end

    for (int p = 0; p < 2; p++) begin
      if (!pend[p]) begin
        if (rand_mode) begin
          if ($urandom_range(0, 1) == 1) newtx(p);
        end else if (rem[p] > 0) begin
          rem[p]--;
          newtx(p);
        end
      end
    end
    if (rand_mode && $urandom_range(0, 15) == 0) lock = ~lock;
    drive();

    if (idle_now) begin
      cpu_ok = pend[0] && !lock;
      gp = -1;
      if (cpu_ok && pend[1]) gp = last_host ? 0 : 1;
      else if (cpu_ok)       gp = 0;
      else if (pend[1])      gp = 1;
      if (gp >= 0) begin
        in_flight = 1;
        g_cyc     = cyc;
        t_port    = gp;
        t_wr      = wr[gp];
        t_addr    = addr[gp];
        t_data    = data[gp];
        last_addr = addr[gp];
        last_data = data[gp];
        last_host = (gp == 1);
      end
    end
  endtask

  task automatic apply_reset();
    reset_in = 1'b0;
    #1;
    chk("rst_busy",      32'(bus.busy_out),      0);
    chk("rst_mem_en",    32'(bus.mem_en_out),    0);
    chk("rst_mem_wr",    32'(bus.mem_wr_out),    0);
    chk("rst_cpu_ack",   32'(bus.cpu_ack_out),   0);
    chk("rst_host_ack",  32'(bus.host_ack_out),  0);
    chk("rst_mem_addr",  32'(bus.mem_addr_out),  0);
    chk("rst_mem_data",  32'(bus.mem_data_out),  0);
    chk("rst_cpu_data",  32'(bus.cpu_data_out),  0);
    chk("rst_host_data", 32'(bus.host_data_out), 0);
    in_flight = 0;
    last_addr = '0;
    last_data = '0;
    last_host = 1;
    held[0]   = '0;
    held[1]   = '0;
    pend[0]   = 0;
    pend[1]   = 0;
    rem[0]    = 0;
    rem[1]    = 0;
    drive();
    @(negedge clock_in);
    reset_in = 1'b1;
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    while ((pend[0] || pend[1] || in_flight) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_timeout", {29'd0, pend[0], pend[1], in_flight}, 0);
  endtask

  task automatic set_tx(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p] = 1;
    wr[p]   = w;
    addr[p] = a;
    data[p] = d;
    rem[p]  = 0;
  endtask

  initial begin
    int mark;
    int nc, nh;
    for (int i = 0; i < 2048; i++) refmem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; wr[p] = 0; addr[p] = '0; data[p] = '0; rem[p] = 0; held[p] = '0;
    end
    drive();
    repeat (2) @(negedge clock_in);
    mem_clr = 1'b0;
    apply_reset();

    // CPU write 0x005 then read back.
    set_tx(0, 1, 11'h005, 16'hA5A5);
    run_idle(20);
    set_tx(0, 0, 11'h005, 16'h0000);
    run_idle(20);
    chk("cpu_rd_a5a5", 32'(bus.cpu_data_out), 32'h0000A5A5);
    repeat (3) step();
    chk("cpu_rd_hold", 32'(bus.cpu_data_out), 32'h0000A5A5);

    // Reset during ACC_CPU after a CPU grant, then contention goes to CPU.
    set_tx(0, 0, 11'h001, 16'h0);
    for (int n = 0; n < 10; n++) begin
      step();
      if (in_flight && cyc == g_cyc + 1) break;
    end
    apply_reset();
    mark = log_port.size();
    set_tx(0, 0, 11'h002, 16'h0);
    set_tx(1, 0, 11'h003, 16'h0);
    run_idle(20);
    chk("rst_first_cpu", 32'(log_port[mark]), 0);

    // Continuous contention from reset: strict alternation 3 cycles apart.
    apply_reset();
    mark = log_port.size();
    newtx(0); rem[0] = 3;
    newtx(1); rem[1] = 3;
    run_idle(60);
    for (int i = 0; i < 4; i++) begin
      chk("alt_order", 32'(log_port[mark+i]), 32'(i % 2));
      chk("alt_gap", 32'(log_cyc[mark+i+1] - log_cyc[mark+i]), 3);
    end

    // Host lock: 12 cycles of both requesting gives 4 host acks only.
    lock = 1;
    newtx(0); rem[0] = 100;
    newtx(1); rem[1] = 100;
    mark = log_port.size();
    repeat (12) step();
    nc = 0; nh = 0;
    for (int i = mark; i < log_port.size(); i++) begin
      if (log_port[i] == 0) nc++;
      else                  nh++;
    end
    chk("lock_host_acks", 32'(nh), 4);
    chk("lock_cpu_acks",  32'(nc), 0);
    lock = 0;
    rem[0] = 0; rem[1] = 0;
    mark = log_port.size();
    run_idle(30);
    chk("unlock_cpu_first", 32'(log_port[mark]), 0);

    // Address switched after grant must not reach the memory.
    set_tx(0, 1, 11'h010, 16'h1234); run_idle(20);
    set_tx(1, 1, 11'h3FF, 16'hBEEF); run_idle(20);
    pg_fixed = 1; pg_addr = 11'h3FF;
    set_tx(0, 0, 11'h010, 16'h0000); run_idle(20);
    pg_fixed = 0;
    chk("post_grant_addr", 32'(bus.cpu_data_out), 32'h00001234);

    // Top address from the host.
    set_tx(1, 1, 11'h7FF, 16'h07FF); run_idle(20);
    set_tx(1, 0, 11'h7FF, 16'h0000); run_idle(20);
    chk("host_top_rd", 32'(bus.host_data_out), 32'h000007FF);

    // Random traffic.
    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    lock = 0;
    run_idle(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
